// File: rtl/mem_dump_tx.sv
// mem_dump_tx: streams a memory range out as a framed byte stream (0xA5, then addr/data pairs)
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start/i_base_addr/i_count dump request;
//        o_mem_rd_en/o_mem_addr/i_mem_rd_data one-cycle-latency memory read port;
//        o_tx_data/o_tx_valid/i_tx_ready byte stream to the UART; o_busy/o_done status.
// Build option: define MEM_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last data byte.
module mem_dump_tx #(
  parameter int MEMORY_DEPTH = 256
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_base_addr,
  input  logic [8:0] i_count,
  output logic       o_mem_rd_en,
  output logic [7:0] o_mem_addr,
  input  logic [7:0] i_mem_rd_data,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_done
);
`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, SYNC, READ, WAIT, ADDR, DATA, CSUM, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, READ, WAIT, ADDR, DATA, FIN} state_t;
`endif
  localparam logic [7:0] ADDR_MASK = (MEMORY_DEPTH >= 256) ? 8'hFF : 8'(MEMORY_DEPTH - 1);
  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) csum_q <= 8'h00;
    else csum_q <= csum_d;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= 8'h00;
      cnt_q   <= 9'd0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end
  // the address counter wraps at 256; only the read port sees the depth mask
  assign o_mem_addr = addr_q & ADDR_MASK;
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    o_tx_valid  = 1'b0;
    o_tx_data   = 8'h00;
    o_mem_rd_en = 1'b0;
    o_done      = 1'b0;
    o_busy      = (state_q != IDLE) && (state_q != FIN);
    case (state_q)
      IDLE: if (i_start) begin
        addr_d  = i_base_addr;
        cnt_d   = i_count;
`ifdef MEM_DUMP_CHECKSUM_EN
        csum_d  = 8'h00;
`endif
        state_d = (i_count == 9'd0) ? FIN : SYNC;
      end
      SYNC: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'hA5;
        state_d    = i_tx_ready ? READ : SYNC;
      end
      READ: begin
        o_mem_rd_en = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        data_d  = i_mem_rd_data;
        state_d = ADDR;
      end
      ADDR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = addr_q;
        state_d    = i_tx_ready ? DATA : ADDR;
      end
      DATA: begin
        o_tx_valid = 1'b1;
        o_tx_data  = data_q;
        if (i_tx_ready) begin
          cnt_d  = cnt_q - 9'd1;
          addr_d = addr_q + 8'd1;
`ifdef MEM_DUMP_CHECKSUM_EN
          csum_d  = csum_q ^ addr_q ^ data_q;
          state_d = (cnt_q == 9'd1) ? CSUM : READ;
`else
          state_d = (cnt_q == 9'd1) ? FIN : READ;
`endif
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      CSUM: begin
        o_tx_valid = 1'b1;
        o_tx_data  = csum_q;
        state_d    = i_tx_ready ? FIN : CSUM;
      end
`endif
      FIN: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_dump_tx.sv
// tb_mem_dump_tx: randomized scoreboard bench for mem_dump_tx against a frame-level reference model
module tb_mem_dump_tx;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_base_addr = 8'h00;
  logic [8:0] i_count = 9'd0;
  logic       o_mem_rd_en;
  logic [7:0] o_mem_addr;
  logic [7:0] i_mem_rd_data = 8'h00;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready = 1'b1;
  logic       o_busy;
  logic       o_done;

  int checks = 0;
  int failures = 0;
  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  int pops = 0;
  int dones = 0;
  int reads = 0;
  bit rnd_ready = 1'b0;
  int stall_n = 0;
  bit hold = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always #5 i_clk = ~i_clk;

  mem_dump_tx dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_count(i_count), .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr),
    .i_mem_rd_data(i_mem_rd_data), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready), .o_busy(o_busy), .o_done(o_done)
  );

  always @(posedge i_clk) if (o_mem_rd_en) i_mem_rd_data <= mem[o_mem_addr];

  always @(posedge i_clk) begin
    #1;
    if (stall_n > 0 && o_tx_valid && o_tx_data == 8'h10) begin
      i_tx_ready = 1'b0;
      stall_n--;
    end else i_tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst_n) hold = 1'b0;
    else begin
      if (hold) begin
        check("hold_valid", 32'(o_tx_valid), 32'd1);
        check("hold_data", 32'(o_tx_data), 32'(hold_data));
      end
      check("rd_while_valid", 32'(o_mem_rd_en & o_tx_valid), 32'd0);
      if (o_mem_rd_en) reads++;
      if (o_done) dones++;
      if (o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte got=%0h exp=none at %0t", o_tx_data, $time);
        end else check("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
        pops++;
      end
      hold = o_tx_valid && !i_tx_ready;
      hold_data = o_tx_data;
    end
  end

  function automatic void push_frame(input logic [7:0] base, input int cnt);
    logic [7:0] a;
    logic [7:0] cs;
    cs = 8'h00;
    if (cnt != 0) exp_q.push_back(8'hA5);
    for (int i = 0; i < cnt; i++) begin
      a = 8'(int'(base) + i);
      exp_q.push_back(a);
      exp_q.push_back(mem[a]);
      cs = cs ^ a ^ mem[a];
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    if (cnt != 0) exp_q.push_back(cs);
`endif
  endfunction

  task automatic start_dump(input logic [7:0] base, input int cnt);
    push_frame(base, cnt);
    reads = 0;
    @(posedge i_clk); #1;
    i_start = 1'b1;
    i_base_addr = base;
    i_count = 9'(cnt);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_base_addr = 8'($urandom);
    i_count = 9'($urandom);
    @(negedge i_clk);
    check("first_valid", 32'(o_tx_valid), (cnt != 0) ? 32'd1 : 32'd0);
    if (cnt != 0) check("first_byte", 32'(o_tx_data), 32'hA5);
  endtask

  task automatic wait_done(input int cnt, output int n);
    for (n = 0; n < 6000 && !o_done; n++) @(negedge i_clk);
    if (n >= 6000) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=no_done exp=done at %0t", $time);
    end else begin
      check("done_queue_empty", 32'(exp_q.size()), 32'd0);
      check("done_busy", 32'(o_busy), 32'd0);
      check("read_count", 32'(reads), 32'(cnt));
      @(negedge i_clk);
      check("done_one_pulse", 32'(o_done), 32'd0);
      check("idle_busy", 32'(o_busy), 32'd0);
    end
  endtask

  initial begin
    int n;
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #3;
    check("reset_outputs", {o_tx_valid, o_mem_rd_en, o_busy, o_done, o_tx_data, o_mem_addr}, 32'd0);
    #20 i_rst_n = 1'b1;

    mem[8'h10] = 8'h3C;
    start_dump(8'h10, 1);
    wait_done(1, n);

    mem[8'hFE] = 8'h01;
    mem[8'hFF] = 8'h00;
    mem[8'h00] = 8'hFF;
    start_dump(8'hFE, 3);
    wait_done(3, n);

    stall_n = 5;
    start_dump(8'h10, 2);
    wait_done(2, n);
    check("stall_applied", 32'(stall_n), 32'd0);

    start_dump(8'h33, 0);
    wait_done(0, n);
    check("count0_done_latency", 32'(n), 32'd0);

    start_dump(8'h40, 6);
    repeat (4) @(posedge i_clk);
    #1;
    check("busy_mid_dump", 32'(o_busy), 32'd1);
    i_start = 1'b1;
    i_base_addr = 8'h80;
    i_count = 9'd9;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_done(6, n);
    repeat (20) @(negedge i_clk);
    check("ignored_start_idle", 32'(o_busy), 32'd0);

    pops = 0;
    start_dump(8'($urandom), 4);
    for (int k = 0; k < 200 && pops < 2; k++) begin
      @(negedge i_clk); #1;
    end
    @(posedge i_clk); #2;
    d0 = dones;
    i_rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {o_tx_valid, o_mem_rd_en, o_busy, o_done, o_tx_data, o_mem_addr}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check("reset_no_done", 32'(dones), 32'(d0));
    start_dump(8'($urandom), 4);
    wait_done(4, n);

    rnd_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      d0 = $urandom_range(1, 24);
      start_dump(8'($urandom), d0);
      wait_done(d0, n);
    end
    rnd_ready = 1'b0;
    start_dump(8'($urandom), 256);
    wait_done(256, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
